// File: rtl/disp_pkg.sv
// Shared types and defaults for the tail-light switch conditioning path.
// Timing defaults assume a 100 MHz system clock.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int DB_CYCLES_DEF   = 1000000;  // 10 ms settle time
  localparam int HOLD_CYCLES_DEF = 2500000;  // 25 ms blanking after a reversal

  // One counter width serves both the debounce and hold counters.
  function automatic int cnt_width(input int db_cycles, input int hold_cycles);
    int max_cycles;
    max_cycles = (db_cycles > hold_cycles) ? db_cycles : hold_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// counter that accepts a new level only after DB_CYCLES consecutive samples.
module sw_debounce
  import disp_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = cnt_width(DB_CYCLES_DEF, HOLD_CYCLES_DEF)
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // NOTE: non-blocking assignments let meta and sync shift as a true
  // two-stage pipeline; blocking ones would collapse them into one flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
    end
  end

  // The counter only runs while the synchronised level disagrees with the
  // accepted one, so it never passes CNT_LAST and cannot wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign dout = stable;

endmodule

// File: rtl/sw_condition.sv
// Switch conditioning top: debounces enable/direction and blanks the enable
// for HOLD_CYCLES after a direction reversal while the display is running.
module sw_condition
  import disp_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_raw,
  output logic [1:0] sw_out,
  output logic       en_db,
  output logic       dir_chg,
  output logic       busy
);

  localparam int               CNT_W     = cnt_width(DB_CYCLES, HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             dir_db;
  logic             dir_q;
  logic             toggle;
  logic             en_gated;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_nxt;

  sw_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_en_db (
    .clk  (clk),
    .reset(reset),
    .din  (sw_raw[0]),
    .dout (en_db)
  );

  sw_debounce #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W)
  ) u_dir_db (
    .clk  (clk),
    .reset(reset),
    .din  (sw_raw[1]),
    .dout (dir_db)
  );

  // dir_q lags dir_db by one cycle, so toggle is high for the single cycle
  // following each accepted direction change.
  assign toggle = dir_db ^ dir_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q   <= 1'b0;
      dir_chg <= 1'b0;
    end else begin
      dir_q   <= dir_db;
      dir_chg <= toggle;
    end
  end

  // NOTE: every output of this block is assigned a default before the case
  // statement, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = '0;
    case (state)
      IDLE: begin
        if (en_db) state_nxt = RUN;
      end
      RUN: begin
        // Losing the enable outranks a simultaneous reversal.
        if (!en_db)      state_nxt = IDLE;
        else if (toggle) state_nxt = HOLD;
      end
      HOLD: begin
        if (!en_db) begin
          state_nxt = IDLE;
        end else if (toggle) begin
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = RUN;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // en_gated and busy are decoded from the next state so they are driven
  // straight from flops and line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      en_gated <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      en_gated <= (state_nxt == RUN);
      busy     <= (state_nxt == HOLD);
    end
  end

  assign sw_out = {dir_db, en_gated};

endmodule

// File: tb/tb_sw_condition.sv
// Self-checking bench for sw_condition: directed scenarios with literal
// expectations plus randomized switch activity checked against a window model.
module tb_sw_condition;

  localparam int DB     = 4;
  localparam int H      = 3;
  localparam int H_LONG = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic [1:0] sw_raw = 2'b00;

  logic [1:0] a_sw_out, b_sw_out;
  logic       a_en_db, b_en_db;
  logic       a_dir_chg, b_dir_chg;
  logic       a_busy, b_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sw_condition #(.DB_CYCLES(DB), .HOLD_CYCLES(H)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_out (a_sw_out),
    .en_db  (a_en_db),
    .dir_chg(a_dir_chg),
    .busy   (a_busy)
  );

  // With HOLD shorter than the debounce time a second accepted flip cannot
  // land inside the window, so a longer-hold copy exercises the restart path.
  sw_condition #(.DB_CYCLES(DB), .HOLD_CYCLES(H_LONG)) u_dut_long (
    .clk    (clk),
    .reset  (reset),
    .sw_raw (sw_raw),
    .sw_out (b_sw_out),
    .en_db  (b_en_db),
    .dir_chg(b_dir_chg),
    .busy   (b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model. A switch level is accepted once the last DB synchronised
  // samples all disagree with the accepted level. mode: 0 idle, 1 run,
  // 2 hold; left counts the blanked cycles still to come.
  typedef struct packed {
    logic [1:0]  d1;
    logic [1:0]  d2;
    logic [1:0]  stab;
    logic [31:0] h0;
    logic [31:0] h1;
    logic        dirq;
    logic        chg;
    logic [1:0]  mode;
    logic [7:0]  left;
  } mdl_t;

  function automatic mdl_t step(input mdl_t m, input logic [1:0] raw, input int hold);
    mdl_t        n    = m;
    logic [31:0] mask = (32'd1 << DB) - 32'd1;
    logic        tog  = m.stab[1] ^ m.dirq;
    n.chg  = tog;
    n.dirq = m.stab[1];
    case (m.mode)
      2'd0: if (m.stab[0]) n.mode = 2'd1;
      2'd1: begin
        if (!m.stab[0]) n.mode = 2'd0;
        else if (tog) begin n.mode = 2'd2; n.left = 8'(hold); end
      end
      default: begin
        if (!m.stab[0])     n.mode = 2'd0;
        else if (tog)       n.left = 8'(hold);
        else if (m.left == 8'd1) n.mode = 2'd1;
        else                n.left = m.left - 8'd1;
      end
    endcase
    n.h0 = {m.h0[30:0], m.d2[0]};
    n.h1 = {m.h1[30:0], m.d2[1]};
    if ((n.h0 & mask) == (m.stab[0] ? 32'd0 : mask)) n.stab[0] = ~m.stab[0];
    if ((n.h1 & mask) == (m.stab[1] ? 32'd0 : mask)) n.stab[1] = ~m.stab[1];
    n.d2 = m.d1;
    n.d1 = raw;
    return n;
  endfunction

  mdl_t ma = '0;
  mdl_t mb = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma <= '0;
      mb <= '0;
    end else begin
      ma <= step(ma, sw_raw, H);
      mb <= step(mb, sw_raw, H_LONG);
    end
  end

  always @(negedge clk) begin
    check("a_sw_out",  a_sw_out,  {ma.stab[1], ma.mode == 2'd1});
    check("a_en_db",   a_en_db,   ma.stab[0]);
    check("a_dir_chg", a_dir_chg, ma.chg);
    check("a_busy",    a_busy,    ma.mode == 2'd2);
    check("b_sw_out",  b_sw_out,  {mb.stab[1], mb.mode == 2'd1});
    check("b_en_db",   b_en_db,   mb.stab[0]);
    check("b_dir_chg", b_dir_chg, mb.chg);
    check("b_busy",    b_busy,    mb.mode == 2'd2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rise_a, rise_b, cnt10, first10, busy_a, chg_a, busy_b, chg_b, first_b, last_b, seen;

    // Reset held with both switches on.
    sw_raw = 2'b11;
    #1 reset = 1'b0;
    repeat (3) begin
      tick();
      check("rst_sw_out", a_sw_out, 2'b00);
      check("rst_en_db",  a_en_db,  1'b0);
      check("rst_busy",   a_busy,   1'b0);
    end
    reset  = 1'b1;
    rise_a = 0;
    rise_b = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (a_en_db && rise_a == 0) rise_a = k;
      if (b_en_db && rise_b == 0) rise_b = k;
    end
    check("en_rise_cycle_a", rise_a, 6);
    check("en_rise_cycle_b", rise_b, 6);

    // Clean restart.
    sw_raw = 2'b00;
    #2 reset = 1'b0;
    #1 check("rst_clear_sw_out", a_sw_out, 2'b00);
    tick();
    reset = 1'b1;

    // Glitch of three cycles on enable.
    sw_raw = 2'b01;
    repeat (3) tick();
    sw_raw = 2'b00;
    seen = 0;
    repeat (10) begin
      tick();
      if (a_en_db || a_sw_out != 2'b00) seen = 1;
    end
    check("glitch_reject", seen, 0);

    // Enable accepted at edge 6, RUN at edge 7.
    sw_raw = 2'b01;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) check("en_db_edge5", a_en_db, 1'b0);
      if (k == 6) begin
        check("en_db_edge6",  a_en_db,  1'b1);
        check("sw_out_edge6", a_sw_out, 2'b00);
      end
      if (k == 7) check("sw_out_edge7", a_sw_out, 2'b01);
    end

    // Reversal while running.
    sw_raw  = 2'b11;
    cnt10   = 0;
    first10 = 0;
    busy_a  = 0;
    chg_a   = 0;
    busy_b  = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (a_sw_out == 2'b10) begin
        cnt10++;
        if (first10 == 0) first10 = k;
      end
      if (a_busy)    busy_a++;
      if (a_dir_chg) chg_a++;
      if (b_busy)    busy_b++;
    end
    check("rev_blank_cycles", cnt10,   3);
    check("rev_first_blank",  first10, 7);
    check("rev_busy_cycles",  busy_a,  3);
    check("rev_dir_chg",      chg_a,   1);
    check("rev_final_sw_out", a_sw_out, 2'b11);
    check("rev_busy_long",    busy_b,  8);

    // Second accepted flip restarts the window.
    sw_raw  = 2'b01;
    busy_a  = 0;
    busy_b  = 0;
    chg_b   = 0;
    first_b = 0;
    last_b  = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 4) sw_raw = 2'b11;
      if (a_busy) busy_a++;
      if (b_busy) begin
        busy_b++;
        if (first_b == 0) first_b = k;
        last_b = k;
      end
      if (b_dir_chg) chg_b++;
    end
    check("retog_busy_long",  busy_b,  12);
    check("retog_first_long", first_b, 7);
    check("retog_last_long",  last_b,  18);
    check("retog_chg_long",   chg_b,   2);
    check("retog_busy_short", busy_a,  6);

    // Enable dropped mid-HOLD.
    sw_raw = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) sw_raw = 2'b00;
      if (k == 10) begin
        check("abort_busy_before", b_busy,   1'b1);
        check("abort_a_run",       a_sw_out, 2'b01);
      end
      if (k == 11) begin
        check("abort_busy_after", b_busy,   1'b0);
        check("abort_sw_out_b",   b_sw_out, 2'b00);
        check("abort_sw_out_a",   a_sw_out, 2'b00);
      end
    end

    // Asynchronous reset in the middle of HOLD.
    sw_raw = 2'b01;
    repeat (8) tick();
    sw_raw = 2'b11;
    repeat (7) tick();
    check("mid_hold_busy_a", a_busy, 1'b1);
    check("mid_hold_busy_b", b_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("async_sw_out_a",  a_sw_out,  2'b00);
    check("async_en_db_a",   a_en_db,   1'b0);
    check("async_dir_chg_a", a_dir_chg, 1'b0);
    check("async_busy_a",    a_busy,    1'b0);
    check("async_sw_out_b",  b_sw_out,  2'b00);
    check("async_busy_b",    b_busy,    1'b0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_sw_out", a_sw_out, 2'b00);
    check("post_rst_busy",   a_busy,   1'b0);
    repeat (6) tick();
    check("idle_flip_sw_out", a_sw_out, 2'b11);
    check("idle_flip_busy",   a_busy,   1'b0);
    tick();
    check("idle_flip_no_hold", a_busy, 1'b0);

    // Randomized activity, enable mostly on so reversals reach HOLD.
    for (int seg = 0; seg < 300; seg++) begin
      sw_raw[0] = ($urandom_range(0, 9) != 0);
      sw_raw[1] = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #3 reset = 1'b0;
        #3 reset = 1'b1;
      end
      repeat ($urandom_range(1, 14)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
